// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - regfile write-port arbiter between in-order WB and a buffered MDU result FIFO
// Define RF_ARB_PERF_EN to add saturating stall-cycle and hold-pulse performance counters.
module rf_wport_arbiter #(
  parameter int XLEN       = 64,
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            mdu_valid_i,
  output logic            mdu_ready_o,
  input  logic [AW-1:0]   mdu_addr_i,
  input  logic [XLEN-1:0] mdu_data_i,
  input  logic            issue_i,
  input  logic [AW-1:0]   issue_addr_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic            stall_o,
  output logic            wb_hold_o,
  output logic            rf_wr_en_o,
  output logic [AW-1:0]   rf_wr_addr_o,
  output logic [XLEN-1:0] rf_wr_data_o
`ifdef RF_ARB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_hold_cnt_o
`endif
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;
  localparam int SW   = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

  logic [AW-1:0]   fifo_addr [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_set;
  logic [NREG-1:0] pending_clr;
  logic [SW-1:0]   starve_cnt;
  logic            wb_win;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [AW-1:0]   head_addr;
  logic [XLEN-1:0] head_data;

  assign fifo_empty = (count == '0);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  // A WB write to x0 is a no-op and leaves the port free for the FIFO head.
  assign wb_win     = wb_valid_i && (wb_addr_i != '0);
  assign pop        = !wb_win && !fifo_empty;
  assign push       = mdu_valid_i && mdu_ready_o;
  assign count_next = count + CW'(push) - CW'(pop);

  always_comb begin
    rf_wr_en_o   = 1'b0;
    rf_wr_addr_o = '0;
    rf_wr_data_o = '0;
    if (wb_win) begin
      rf_wr_en_o   = 1'b1;
      rf_wr_addr_o = wb_addr_i;
      rf_wr_data_o = wb_data_i;
    end else if (pop) begin
      rf_wr_en_o   = (head_addr != '0);
      rf_wr_addr_o = head_addr;
      rf_wr_data_o = head_data;
    end
  end

  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (issue_i && (issue_addr_i != '0)) pending_set[issue_addr_i] = 1'b1;
    if (pop) pending_clr[head_addr] = 1'b1;
  end

  assign stall_o = pending[rs1_addr_i] | pending[rs2_addr_i] | (issue_i & pending[issue_addr_i]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mdu_addr_i;
      fifo_data[wr_ptr] <= mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mdu_ready_o <= 1'b0;
      pending     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      mdu_ready_o <= (count_next < CW'(DEPTH));
      // Set is applied after clear so a same-cycle reissue of the popped rd stays pending.
      pending     <= ((pending & ~pending_clr) | pending_set) & ~NREG'(1);
    end
  end

  // Outside the empty/pop cases the head is losing to WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_hold_o  <= 1'b0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
      wb_hold_o  <= 1'b0;
    end else if (starve_cnt == SW'(STARVE_LIM - 1)) begin
      starve_cnt <= '0;
      wb_hold_o  <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
      wb_hold_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(wb_hold_o && wb_win))
        else $error("rf_wport_arbiter: WB write presented during wb_hold_o");
    end
  end

`ifdef RF_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_hold_cnt_o  <= '0;
    end else begin
      if (stall_o && (perf_stall_cnt_o != '1)) perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
      if (wb_hold_o && (perf_hold_cnt_o != '1)) perf_hold_cnt_o <= perf_hold_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - self-checking bench for rf_wport_arbiter against a queue-based reference model
module tb_rf_wport_arbiter;
  localparam int XLEN       = 64;
  localparam int AW         = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_LIM = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [AW-1:0]   mdu_addr;
  logic [XLEN-1:0] mdu_data;
  logic            issue;
  logic [AW-1:0]   issue_addr;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            stall;
  logic            wb_hold;
  logic            rf_wr_en;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
`ifdef RF_ARB_PERF_EN
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_hold_cnt;
`endif

  always #5 clk = ~clk;

  rf_wport_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .mdu_valid_i(mdu_valid), .mdu_ready_o(mdu_ready), .mdu_addr_i(mdu_addr), .mdu_data_i(mdu_data),
    .issue_i(issue), .issue_addr_i(issue_addr), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .stall_o(stall), .wb_hold_o(wb_hold),
    .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data)
`ifdef RF_ARB_PERF_EN
    , .perf_stall_cnt_o(perf_stall_cnt), .perf_hold_cnt_o(perf_hold_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t        fifo_q[$];
  ent_t        outq[$];
  logic [31:0] m_pend;
  int          lost_streak;
  bit          m_ready;
  bit          m_hold;
  int          n_tests;
  int          n_fail;
  string       step_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step_tag, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    m_pend      = '0;
    lost_streak = 0;
    m_ready     = 1'b0;
    m_hold      = 1'b0;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    issue = 1'b0; issue_addr = '0; rs1 = '0; rs2 = '0;
  endtask

  // Check one cycle's outputs against the model, then advance model and DUT by one clock.
  task automatic cyc();
    bit              win;
    bit              was_empty;
    bit              do_pop;
    bit              exp_en;
    bit              exp_stall;
    logic [AW-1:0]   exp_a;
    logic [XLEN-1:0] exp_d;
    ent_t            e;
    #1;
    win       = wb_valid && (wb_addr != '0);
    was_empty = (fifo_q.size() == 0);
    do_pop    = !win && !was_empty;
    exp_en = 1'b0; exp_a = '0; exp_d = '0;
    if (win) begin
      exp_en = 1'b1; exp_a = wb_addr; exp_d = wb_data;
    end else if (do_pop) begin
      exp_en = (fifo_q[0].addr != '0); exp_a = fifo_q[0].addr; exp_d = fifo_q[0].data;
    end
    exp_stall = m_pend[rs1] | m_pend[rs2] | (issue & m_pend[issue_addr]);
    chk("rf_wr_en", 64'(rf_wr_en), 64'(exp_en));
    if (exp_en) begin
      chk("rf_wr_addr", 64'(rf_wr_addr), 64'(exp_a));
      chk("rf_wr_data", rf_wr_data, exp_d);
    end
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("mdu_ready", 64'(mdu_ready), 64'(m_ready));
    chk("wb_hold", 64'(wb_hold), 64'(m_hold));
    if (do_pop) begin
      e = fifo_q.pop_front();
      m_pend[e.addr] = 1'b0;
    end
    if (mdu_valid && m_ready) begin
      e.addr = mdu_addr; e.data = mdu_data;
      fifo_q.push_back(e);
    end
    if (issue && (issue_addr != '0)) m_pend[issue_addr] = 1'b1;
    m_pend[0] = 1'b0;
    if (was_empty || do_pop) lost_streak = 0;
    else lost_streak++;
    m_hold = (lost_streak == STARVE_LIM);
    if (m_hold) lost_streak = 0;
    m_ready = (fifo_q.size() < DEPTH);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit   accepted;
    ent_t op;
    n_tests = 0;
    n_fail  = 0;
    step_tag = "reset";
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ready", 64'(mdu_ready), 64'd0);
    chk("rst_hold", 64'(wb_hold), 64'd0);
    chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();

    // Single MDU result to x5 reaches the regfile the cycle after the push.
    step_tag = "t1";
    idle(); issue = 1'b1; issue_addr = 5'd5; cyc();
    idle(); mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 64'hABCD; rs1 = 5'd5; cyc();
    idle(); rs1 = 5'd5;
    #1;
    chk("t1_wr_en", 64'(rf_wr_en), 64'd1);
    chk("t1_wr_addr", 64'(rf_wr_addr), 64'd5);
    chk("t1_wr_data", rf_wr_data, 64'hABCD);
    cyc();
    chk("t1_cleared", 64'(stall), 64'd0);
    cyc();

    // RAW stall on x9 held until its result pops.
    step_tag = "t3";
    idle(); issue = 1'b1; issue_addr = 5'd9; cyc();
    idle(); rs1 = 5'd9; cyc(); cyc(); cyc();
    idle(); rs1 = 5'd9; mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 64'h1234_5678_9ABC_DEF0; cyc();
    idle(); rs1 = 5'd9; cyc();
    chk("t3_release", 64'(stall), 64'd0);
    cyc();

    // Starvation: x7 queued while WB writes x3 every cycle.
    step_tag = "t2";
    idle(); issue = 1'b1; issue_addr = 5'd7; cyc();
    idle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h33;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 64'h77; cyc();
    mdu_valid = 1'b0;
    for (int i = 0; i < STARVE_LIM; i++) cyc();
    chk("t2_hold_set", 64'(wb_hold), 64'd1);
    idle(); cyc();
    chk("t2_hold_clear", 64'(wb_hold), 64'd0);
    cyc();

    // Fill both FIFO slots under continuous WB, then release.
    step_tag = "t4";
    idle(); issue = 1'b1; issue_addr = 5'd10; cyc();
    idle(); issue = 1'b1; issue_addr = 5'd11; cyc();
    idle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h3A;
    mdu_valid = 1'b1; mdu_addr = 5'd10; mdu_data = 64'hA0; cyc();
    mdu_addr = 5'd11; mdu_data = 64'hB0; cyc();
    mdu_valid = 1'b0;
    chk("t4_full", 64'(mdu_ready), 64'd0);
    cyc(); cyc();
    wb_valid = 1'b0; cyc();
    chk("t4_ready_back", 64'(mdu_ready), 64'd1);
    cyc(); cyc();

    // WB to x0 does not take the port; MDU result to x0 pops silently.
    step_tag = "t5";
    idle(); issue = 1'b1; issue_addr = 5'd12; cyc();
    idle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 64'h3C;
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 64'hC12; cyc();
    idle(); wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hDEAD; cyc();
    idle(); mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 64'hBEEF; cyc();
    idle(); cyc();
    cyc();

    // Reset with two entries queued.
    step_tag = "t6";
    idle(); issue = 1'b1; issue_addr = 5'd13; cyc();
    idle(); issue = 1'b1; issue_addr = 5'd14; cyc();
    idle(); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 64'h44;
    mdu_valid = 1'b1; mdu_addr = 5'd13; mdu_data = 64'hD13; cyc();
    mdu_addr = 5'd14; mdu_data = 64'hD14; cyc();
    idle(); rs1 = 5'd13; rs2 = 5'd14;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_stall", 64'(stall), 64'd0);
    chk("t6_wr_en", 64'(rf_wr_en), 64'd0);
    chk("t6_ready", 64'(mdu_ready), 64'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(); cyc(); cyc();

    // Randomized traffic with an MDU that only returns issued ops, in order.
    step_tag = "rand";
    outq.delete();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rs1        = AW'($urandom_range(0, 31));
      rs2        = AW'($urandom_range(0, 31));
      issue_addr = AW'($urandom_range(0, 31));
      if (($urandom_range(0, 3) == 0) && (outq.size() < 4) &&
          !(m_pend[rs1] | m_pend[rs2] | m_pend[issue_addr])) issue = 1'b1;
      wb_valid = ($urandom_range(0, 2) != 0) && !m_hold;
      wb_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
      wb_data  = {$urandom, $urandom};
      if ((outq.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        mdu_valid = 1'b1;
        mdu_addr  = outq[0].addr;
        mdu_data  = outq[0].data;
      end
      accepted = mdu_valid && m_ready;
      op.addr  = issue_addr;
      op.data  = {$urandom, $urandom};
      cyc();
      if (accepted) void'(outq.pop_front());
      if (issue) outq.push_back(op);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
